clock_divider_multi: RTL
========================

Name: clock_divider_multi

Overview:
- NCH-channel programmable integer clock divider; successor to the fixed even-N divider.
- Each channel produces a divided clock level (clk_out) and a one-cycle period-start strobe (tick).
- Supports odd and even ratios, runtime ratio reload at period boundaries, graceful stop, and a global phase-align input.
- Sits in the clocking/timebase area and feeds clock enables to downstream logic on the same clk.

Parameters:
- NCH, 4, number of independent divider channels (≥1)
- DIV_W, 8, width of each divide ratio; ratios 1..2^DIV_W-1
- DEFAULT_DIV, 4, active ratio loaded into every channel at reset (1..2^DIV_W-1)

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- en  input  NCH  per-channel run enable
- load  input  NCH  per-channel strobe: capture div slice as the new ratio
- div  input  NCH*DIV_W  packed ratios; channel i uses bits [i*DIV_W +: DIV_W]
- sync  input  1  phase-align strobe for all running channels
- clk_out  output  NCH  divided clock level per channel
- tick  output  NCH  one-cycle strobe on the first cycle of each period
- busy  output  NCH  channel is running, including a graceful-stop tail

Behaviour:
- Clocking and reset: all state updates on posedge clk. Reset is synchronous, active-high, and overrides all other inputs.
- Reset values per channel:
  - cnt=0, D=DEFAULT_DIV, pend=0, run=0
  - clk_out=0, tick=0, busy=0
- Outputs are flops. Define H = (D+1)>>1, so clk_out is high for ceil(D/2) cycles and low for floor(D/2) cycles.
- Per-channel state: IDLE (run=0) and RUN (run=1).
- IDLE → RUN when en=1 at an edge. That same edge sets cnt<=0, clk_out<=1, tick<=1, busy<=1. Latency from en sampled high to first tick is 1 edge.
- RUN, cnt<D-1: cnt<=cnt+1, clk_out<=(cnt+1<H), tick<=0.
- RUN, cnt==D-1 (wrap edge):
  - The new ratio D' is selected as follows: load this cycle gives the div slice; otherwise pend gives the pending value; otherwise D is unchanged. Clear pend.
  - If en=1: cnt<=0, D<=D', clk_out<=1, tick<=1.
  - If en=0: go to IDLE with clk_out<=0, tick<=0, busy<=0, D<=D'. This is a graceful stop; a period is never truncated.
- Ratio loading:
  - load in RUN on a non-wrap edge: store the div slice in the pending register and set pend=1. A later load overwrites it; last write wins.
  - load in IDLE: D<=div slice immediately.
- div slice value 0: ignored (D and pend unchanged). No error flag.
- D=1: clk_out stays high and tick=1 every cycle.
- sync=1 at an edge: every channel in RUN with en=1 restarts (cnt<=0, clk_out<=1, tick<=1). A pending ratio is applied at that restart.
  - Channels in IDLE or in a stop tail are unaffected.
  - sync has priority over the normal count on the same edge.
- en deasserted then reasserted before the wrap: the channel keeps running with no glitch.
- Reset asserted mid-period: outputs drop to 0 on that edge.
- Channels are fully independent except for the shared sync input.

Decomposition:
- Package clkdiv_pkg holds:
  - localparam defaults NCH_DEF and DIV_W_DEF
  - function half_high(D) = (D+1)>>1
  - typedef div_t = logic [DIV_W_DEF-1:0]
- Sub-module clkdiv_channel implements one channel (cnt, D, pend, run, and the three output flops).
- The top level generates NCH instances, slices div, and fans out sync.

Test Plan:
- Reset with en=0 → all outputs 0. Hold en[0]=1 → after 1 edge tick[0]=1; clk_out[0] pattern is 1,1,0,0 repeating (D=4).
- load[1] with div=5 while idle, then en[1]=1 → clk_out[1] high 3 cycles, low 2, period 5; tick every 5th cycle.
- Running at D=4, load div=7 at cnt=1 → current period completes at 4 cycles; next period is 7 cycles (high 4, low 3).
- Drop en[2] at cnt=1 of a D=6 period → clk_out completes the 6-cycle period, then busy[2]=0 with no further tick. Also load div=0 → ignored.
- ch0 at D=4 and ch1 at D=6 running; pulse sync → both tick on the same next edge and clk_out rises together.
- Assert reset at cnt=2 of a D=8 period → all outputs 0 on that edge; after release with en=1, the D=DEFAULT_DIV pattern restarts.

Source files
------------

// File: rtl/clock_divider_multi_pkg.sv
// ---------------------------------------------------------------------------
// clkdiv_pkg
//   Shared definitions for the multi-channel programmable clock divider.
//   - NCH_DEF / DIV_W_DEF : default channel count and ratio width
//   - div_t               : one divide ratio at the default width
//   - ch_state_t          : per-channel run state
//   - half_high()         : number of cycles clk_out is high in a period
// ---------------------------------------------------------------------------
package clkdiv_pkg;

  localparam int NCH_DEF   = 4;
  localparam int DIV_W_DEF = 8;

  typedef logic [DIV_W_DEF-1:0] div_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } ch_state_t;

  // High phase is ceil(D/2), so odd ratios spend the extra cycle high.
  function automatic int unsigned half_high(input int unsigned d);
    return (d + 1) >> 1;
  endfunction

endpackage

// File: rtl/clock_divider_multi_channel.sv
// ---------------------------------------------------------------------------
// clkdiv_channel
//   One programmable integer divider channel.
//   Ports:
//     clk, reset     system clock, synchronous active-high reset
//     en             run enable; dropping it stops at the end of the period
//     load, div      ratio reload strobe and value (0 is ignored)
//     sync           restart a running channel at the start of a period
//     clk_out        divided clock level (high ceil(D/2), low floor(D/2))
//     tick           one-cycle strobe on the first cycle of each period
//     busy           channel running, including the graceful-stop tail
// ---------------------------------------------------------------------------
module clkdiv_channel
  import clkdiv_pkg::*;
#(
  parameter int DIV_W       = DIV_W_DEF,
  parameter int DEFAULT_DIV = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             load,
  input  logic [DIV_W-1:0] div,
  input  logic             sync,
  output logic             clk_out,
  output logic             tick,
  output logic             busy
);

  localparam logic [DIV_W-1:0] DEF_D = DIV_W'(DEFAULT_DIV);
  localparam logic [DIV_W-1:0] ONE   = DIV_W'(1);

  ch_state_t        state_q, state_d;
  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [DIV_W-1:0] d_q, d_d;
  logic             pend_q, pend_d;
  logic [DIV_W-1:0] pend_val_q, pend_val_d;
  logic             clk_out_d, tick_d, busy_d;

  logic             load_ok;
  logic             wrap;
  logic [DIV_W-1:0] d_sel;
  logic [DIV_W-1:0] cnt_inc;

  assign load_ok = load && (div != '0);
  assign wrap    = (cnt_q == d_q - ONE);
  assign cnt_inc = cnt_q + ONE;
  // Ratio for the next period: a load on this edge beats the pending value.
  assign d_sel   = load_ok ? div : (pend_q ? pend_val_q : d_q);

  // NOTE: every variable gets a default before the case so no path leaves
  // one unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    d_d        = d_q;
    pend_d     = pend_q;
    pend_val_d = pend_val_q;
    clk_out_d  = clk_out;
    tick_d     = 1'b0;
    busy_d     = busy;

    unique case (state_q)
      ST_IDLE: begin
        if (load_ok) d_d = div;
        if (en) begin
          state_d   = ST_RUN;
          cnt_d     = '0;
          clk_out_d = 1'b1;
          tick_d    = 1'b1;
          busy_d    = 1'b1;
        end
      end

      ST_RUN: begin
        // A period boundary: natural wrap, or sync on a channel still
        // enabled. A stop tail (en=0) ignores sync and finishes its period.
        if (wrap || (sync && en)) begin
          d_d    = d_sel;
          pend_d = 1'b0;
          cnt_d  = '0;
          if (en) begin
            clk_out_d = 1'b1;
            tick_d    = 1'b1;
          end else begin
            state_d   = ST_IDLE;
            clk_out_d = 1'b0;
            busy_d    = 1'b0;
          end
        end else begin
          cnt_d     = cnt_inc;
          clk_out_d = (32'(cnt_inc) < half_high(32'(d_q)));
          if (load_ok) begin
            pend_d     = 1'b1;
            pend_val_d = div;
          end
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      d_q        <= DEF_D;
      pend_q     <= 1'b0;
      pend_val_q <= '0;
      clk_out    <= 1'b0;
      tick       <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      d_q        <= d_d;
      pend_q     <= pend_d;
      pend_val_q <= pend_val_d;
      clk_out    <= clk_out_d;
      tick       <= tick_d;
      busy       <= busy_d;
    end
  end

endmodule

// File: rtl/clock_divider_multi.sv
// ---------------------------------------------------------------------------
// clock_divider_multi
//   NCH independent programmable integer clock dividers sharing one sync.
//   Ports:
//     clk, reset  system clock, synchronous active-high reset
//     en[NCH]     per-channel run enable
//     load[NCH]   per-channel ratio load strobe
//     div         packed ratios, channel i at [i*DIV_W +: DIV_W]
//     sync        phase-align strobe for all running channels
//     clk_out     divided clock level per channel
//     tick        period-start strobe per channel
//     busy        per-channel running indication
// ---------------------------------------------------------------------------
module clock_divider_multi
  import clkdiv_pkg::*;
#(
  parameter int NCH         = NCH_DEF,
  parameter int DIV_W       = DIV_W_DEF,
  parameter int DEFAULT_DIV = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NCH-1:0]       en,
  input  logic [NCH-1:0]       load,
  input  logic [NCH*DIV_W-1:0] div,
  input  logic                 sync,
  output logic [NCH-1:0]       clk_out,
  output logic [NCH-1:0]       tick,
  output logic [NCH-1:0]       busy
);

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    clkdiv_channel #(
      .DIV_W       (DIV_W),
      .DEFAULT_DIV (DEFAULT_DIV)
    ) u_ch (
      .clk     (clk),
      .reset   (reset),
      .en      (en[i]),
      .load    (load[i]),
      .div     (div[i*DIV_W +: DIV_W]),
      .sync    (sync),
      .clk_out (clk_out[i]),
      .tick    (tick[i]),
      .busy    (busy[i])
    );
  end

endmodule
